// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the 6502 instruction encoder.
// Holds the addressing-mode and index codes (the same codes the CPU decoder
// produces), the sequential mnemonic codes, instruction length codes, the
// FSM state type and the latched request payload.
package instr_encoder_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned MODE_W = 5;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OPND_W = 16;
   localparam int unsigned LEN_W  = 2;

   // Addressing modes
   localparam logic [MODE_W-1:0] ADR_INVAL       = 5'd0;
   localparam logic [MODE_W-1:0] ADR_IMPL        = 5'd1;
   localparam logic [MODE_W-1:0] ADR_ACCUM       = 5'd2;
   localparam logic [MODE_W-1:0] ADR_IMM         = 5'd3;
   localparam logic [MODE_W-1:0] ADR_ZPG         = 5'd4;
   localparam logic [MODE_W-1:0] ADR_ZPG_X_Y     = 5'd5;
   localparam logic [MODE_W-1:0] ADR_ABS         = 5'd6;
   localparam logic [MODE_W-1:0] ADR_ABS_X_Y     = 5'd7;
   localparam logic [MODE_W-1:0] ADR_ABS_X_IND   = 5'd8;
   localparam logic [MODE_W-1:0] ADR_ZPG_IND_Y   = 5'd9;
   localparam logic [MODE_W-1:0] ADR_REL         = 5'd10;
   localparam logic [MODE_W-1:0] ADR_ABS_JMP     = 5'd11;
   localparam logic [MODE_W-1:0] ADR_ABS_IND     = 5'd12;
   localparam logic [MODE_W-1:0] ADR_ABS_JSR     = 5'd13;
   localparam logic [MODE_W-1:0] ADR_STACK_PUSH  = 5'd14;
   localparam logic [MODE_W-1:0] ADR_STACK_PULL  = 5'd15;
   localparam logic [MODE_W-1:0] ADR_STACK_RTS   = 5'd16;
   localparam logic [MODE_W-1:0] ADR_STACK_RTI   = 5'd17;
   localparam logic [MODE_W-1:0] ADR_STACK_BRK   = 5'd18;
   localparam logic [MODE_W-1:0] ADR_ZPG_RMW     = 5'd19;
   localparam logic [MODE_W-1:0] ADR_ZPG_X_Y_RMW = 5'd20;
   localparam logic [MODE_W-1:0] ADR_ABS_RMW     = 5'd21;
   localparam logic [MODE_W-1:0] ADR_ABS_X_Y_RMW = 5'd22;

   localparam logic ADR_INDEX_X = 1'b0;
   localparam logic ADR_INDEX_Y = 1'b1;

   // Mnemonics (sequential)
   localparam logic [OP_W-1:0] OP_ORA = 6'd0;
   localparam logic [OP_W-1:0] OP_AND = 6'd1;
   localparam logic [OP_W-1:0] OP_EOR = 6'd2;
   localparam logic [OP_W-1:0] OP_ADC = 6'd3;
   localparam logic [OP_W-1:0] OP_STA = 6'd4;
   localparam logic [OP_W-1:0] OP_LDA = 6'd5;
   localparam logic [OP_W-1:0] OP_CMP = 6'd6;
   localparam logic [OP_W-1:0] OP_SBC = 6'd7;
   localparam logic [OP_W-1:0] OP_ASL = 6'd8;
   localparam logic [OP_W-1:0] OP_ROL = 6'd9;
   localparam logic [OP_W-1:0] OP_LSR = 6'd10;
   localparam logic [OP_W-1:0] OP_ROR = 6'd11;
   localparam logic [OP_W-1:0] OP_INC = 6'd12;
   localparam logic [OP_W-1:0] OP_DEC = 6'd13;
   localparam logic [OP_W-1:0] OP_STX = 6'd14;
   localparam logic [OP_W-1:0] OP_STY = 6'd15;
   localparam logic [OP_W-1:0] OP_LDX = 6'd16;
   localparam logic [OP_W-1:0] OP_LDY = 6'd17;
   localparam logic [OP_W-1:0] OP_CPX = 6'd18;
   localparam logic [OP_W-1:0] OP_CPY = 6'd19;
   localparam logic [OP_W-1:0] OP_INX = 6'd20;
   localparam logic [OP_W-1:0] OP_INY = 6'd21;
   localparam logic [OP_W-1:0] OP_DEX = 6'd22;
   localparam logic [OP_W-1:0] OP_DEY = 6'd23;
   localparam logic [OP_W-1:0] OP_TAX = 6'd24;
   localparam logic [OP_W-1:0] OP_TXA = 6'd25;
   localparam logic [OP_W-1:0] OP_TAY = 6'd26;
   localparam logic [OP_W-1:0] OP_TYA = 6'd27;
   localparam logic [OP_W-1:0] OP_TXS = 6'd28;
   localparam logic [OP_W-1:0] OP_TSX = 6'd29;
   localparam logic [OP_W-1:0] OP_PHA = 6'd30;
   localparam logic [OP_W-1:0] OP_PLA = 6'd31;
   localparam logic [OP_W-1:0] OP_BPL = 6'd32;
   localparam logic [OP_W-1:0] OP_BMI = 6'd33;
   localparam logic [OP_W-1:0] OP_BVC = 6'd34;
   localparam logic [OP_W-1:0] OP_BVS = 6'd35;
   localparam logic [OP_W-1:0] OP_BCC = 6'd36;
   localparam logic [OP_W-1:0] OP_BCS = 6'd37;
   localparam logic [OP_W-1:0] OP_BNE = 6'd38;
   localparam logic [OP_W-1:0] OP_BEQ = 6'd39;
   localparam logic [OP_W-1:0] OP_CLC = 6'd40;
   localparam logic [OP_W-1:0] OP_SEC = 6'd41;
   localparam logic [OP_W-1:0] OP_CLI = 6'd42;
   localparam logic [OP_W-1:0] OP_SEI = 6'd43;
   localparam logic [OP_W-1:0] OP_CLV = 6'd44;
   localparam logic [OP_W-1:0] OP_CLD = 6'd45;
   localparam logic [OP_W-1:0] OP_SED = 6'd46;
   localparam logic [OP_W-1:0] OP_JMP = 6'd47;
   localparam logic [OP_W-1:0] OP_JSR = 6'd48;
   localparam logic [OP_W-1:0] OP_RTS = 6'd49;
   localparam logic [OP_W-1:0] OP_RTI = 6'd50;
   localparam logic [OP_W-1:0] OP_BRK = 6'd51;

   // Instruction length codes; ILEN_NONE marks a mode with no encoding
   localparam logic [LEN_W-1:0] ILEN_NONE = 2'd0;
   localparam logic [LEN_W-1:0] ILEN_1    = 2'd1;
   localparam logic [LEN_W-1:0] ILEN_2    = 2'd2;
   localparam logic [LEN_W-1:0] ILEN_3    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK,
      ST_OPC,
      ST_LO,
      ST_HI
   } enc_state_e;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [MODE_W-1:0] mode;
      logic              index;
      logic [OPND_W-1:0] operand;
   } enc_req_t;

   // Read-modify-write mode codes encode exactly like their plain forms
   function automatic logic [MODE_W-1:0] norm_mode(input logic [MODE_W-1:0] m);
      case (m)
         ADR_ZPG_RMW:     return ADR_ZPG;
         ADR_ZPG_X_Y_RMW: return ADR_ZPG_X_Y;
         ADR_ABS_RMW:     return ADR_ABS;
         ADR_ABS_X_Y_RMW: return ADR_ABS_X_Y;
         default:         return m;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_opcode_lut.sv
// Combinational opcode table: maps (mnemonic, addressing mode, index) to the
// 6502 opcode byte and instruction length, flagging illegal combinations.
// Ports: op, adr_mode, index in; opcode[7:0], len[1:0], illegal out.
module opcode_lut
   import instr_encoder_pkg::*;
(
   input  logic [5:0] op,
   input  logic [4:0] adr_mode,
   input  logic       index,
   output logic [7:0] opcode,
   output logic [1:0] len,
   output logic       illegal
);

   logic [MODE_W-1:0] mode;
   logic [LEN_W-1:0]  len_m;
   logic [2:0]        aaa;
   logic [2:0]        bbb;
   logic [BYTE_W-1:0] opc;
   logic              ok;

   assign mode = norm_mode(adr_mode);

   // Length is a property of the addressing mode alone
   always_comb begin
      case (mode)
         ADR_IMPL, ADR_ACCUM, ADR_STACK_PUSH, ADR_STACK_PULL,
         ADR_STACK_RTS, ADR_STACK_RTI, ADR_STACK_BRK:
            len_m = ILEN_1;
         ADR_IMM, ADR_ZPG, ADR_ZPG_X_Y, ADR_REL, ADR_ABS_X_IND, ADR_ZPG_IND_Y:
            len_m = ILEN_2;
         ADR_ABS, ADR_ABS_X_Y, ADR_ABS_JMP, ADR_ABS_IND, ADR_ABS_JSR:
            len_m = ILEN_3;
         default:
            len_m = ILEN_NONE;
      endcase
   end

   // Opcode selection and legality per mnemonic
   always_comb begin
      opc = 8'h00;
      ok  = 1'b1;
      aaa = 3'b000;
      bbb = 3'b000;
      case (op)
         OP_ORA, OP_AND, OP_EOR, OP_ADC, OP_STA, OP_LDA, OP_CMP, OP_SBC: begin
            case (mode)
               ADR_ABS_X_IND: bbb = 3'b000;
               ADR_ZPG:       bbb = 3'b001;
               ADR_IMM: begin
                  bbb = 3'b010;
                  ok  = (op != OP_STA);
               end
               ADR_ABS:       bbb = 3'b011;
               ADR_ZPG_IND_Y: bbb = 3'b100;
               ADR_ZPG_X_Y: begin
                  bbb = 3'b101;
                  ok  = (index == ADR_INDEX_X);
               end
               ADR_ABS_X_Y:   bbb = (index == ADR_INDEX_Y) ? 3'b110 : 3'b111;
               default:       ok  = 1'b0;
            endcase
            opc = {op[2:0], bbb, 2'b01};
         end
         OP_ASL, OP_ROL, OP_LSR, OP_ROR, OP_INC, OP_DEC: begin
            case (op)
               OP_ROL:  aaa = 3'b001;
               OP_LSR:  aaa = 3'b010;
               OP_ROR:  aaa = 3'b011;
               OP_DEC:  aaa = 3'b110;
               OP_INC:  aaa = 3'b111;
               default: aaa = 3'b000;
            endcase
            case (mode)
               ADR_ACCUM: begin
                  bbb = 3'b010;
                  ok  = (op != OP_INC) && (op != OP_DEC);
               end
               ADR_ZPG: bbb = 3'b001;
               ADR_ABS: bbb = 3'b011;
               ADR_ZPG_X_Y: begin
                  bbb = 3'b101;
                  ok  = (index == ADR_INDEX_X);
               end
               ADR_ABS_X_Y: begin
                  bbb = 3'b111;
                  ok  = (index == ADR_INDEX_X);
               end
               default: ok = 1'b0;
            endcase
            opc = {aaa, bbb, 2'b10};
         end
         OP_STX: begin
            case (mode)
               ADR_ZPG: opc = 8'h86;
               ADR_ABS: opc = 8'h8E;
               ADR_ZPG_X_Y: begin
                  opc = 8'h96;
                  ok  = (index == ADR_INDEX_Y);
               end
               default: ok = 1'b0;
            endcase
         end
         OP_STY: begin
            case (mode)
               ADR_ZPG: opc = 8'h84;
               ADR_ABS: opc = 8'h8C;
               ADR_ZPG_X_Y: begin
                  opc = 8'h94;
                  ok  = (index == ADR_INDEX_X);
               end
               default: ok = 1'b0;
            endcase
         end
         OP_LDX: begin
            case (mode)
               ADR_IMM: opc = 8'hA2;
               ADR_ZPG: opc = 8'hA6;
               ADR_ABS: opc = 8'hAE;
               ADR_ZPG_X_Y: begin
                  opc = 8'hB6;
                  ok  = (index == ADR_INDEX_Y);
               end
               ADR_ABS_X_Y: begin
                  opc = 8'hBE;
                  ok  = (index == ADR_INDEX_Y);
               end
               default: ok = 1'b0;
            endcase
         end
         OP_LDY: begin
            case (mode)
               ADR_IMM: opc = 8'hA0;
               ADR_ZPG: opc = 8'hA4;
               ADR_ABS: opc = 8'hAC;
               ADR_ZPG_X_Y: begin
                  opc = 8'hB4;
                  ok  = (index == ADR_INDEX_X);
               end
               ADR_ABS_X_Y: begin
                  opc = 8'hBC;
                  ok  = (index == ADR_INDEX_X);
               end
               default: ok = 1'b0;
            endcase
         end
         OP_CPX, OP_CPY: begin
            case (mode)
               ADR_IMM: opc = (op == OP_CPX) ? 8'hE0 : 8'hC0;
               ADR_ZPG: opc = (op == OP_CPX) ? 8'hE4 : 8'hC4;
               ADR_ABS: opc = (op == OP_CPX) ? 8'hEC : 8'hCC;
               default: ok  = 1'b0;
            endcase
         end
         OP_INX, OP_INY, OP_DEX, OP_DEY, OP_TAX, OP_TXA, OP_TAY, OP_TYA,
         OP_TXS, OP_TSX, OP_CLC, OP_SEC, OP_CLI, OP_SEI, OP_CLV, OP_CLD,
         OP_SED: begin
            ok = (mode == ADR_IMPL);
            case (op)
               OP_INX:  opc = 8'hE8;
               OP_INY:  opc = 8'hC8;
               OP_DEX:  opc = 8'hCA;
               OP_DEY:  opc = 8'h88;
               OP_TAX:  opc = 8'hAA;
               OP_TXA:  opc = 8'h8A;
               OP_TAY:  opc = 8'hA8;
               OP_TYA:  opc = 8'h98;
               OP_TXS:  opc = 8'h9A;
               OP_TSX:  opc = 8'hBA;
               OP_CLC:  opc = 8'h18;
               OP_SEC:  opc = 8'h38;
               OP_CLI:  opc = 8'h58;
               OP_SEI:  opc = 8'h78;
               OP_CLV:  opc = 8'hB8;
               OP_CLD:  opc = 8'hD8;
               default: opc = 8'hF8;
            endcase
         end
         // Branch condition code sits in the top three opcode bits
         OP_BPL, OP_BMI, OP_BVC, OP_BVS, OP_BCC, OP_BCS, OP_BNE, OP_BEQ: begin
            opc = {op[2:0], 5'b10000};
            ok  = (mode == ADR_REL);
         end
         OP_PHA: begin
            opc = 8'h48;
            ok  = (mode == ADR_STACK_PUSH);
         end
         OP_PLA: begin
            opc = 8'h68;
            ok  = (mode == ADR_STACK_PULL);
         end
         OP_RTS: begin
            opc = 8'h60;
            ok  = (mode == ADR_STACK_RTS);
         end
         OP_RTI: begin
            opc = 8'h40;
            ok  = (mode == ADR_STACK_RTI);
         end
         OP_BRK: begin
            opc = 8'h00;
            ok  = (mode == ADR_STACK_BRK);
         end
         OP_JMP: begin
            case (mode)
               ADR_ABS, ADR_ABS_JMP: opc = 8'h4C;
               ADR_ABS_IND:          opc = 8'h6C;
               default:              ok  = 1'b0;
            endcase
         end
         OP_JSR: begin
            opc = 8'h20;
            ok  = (mode == ADR_ABS_JSR) || (mode == ADR_ABS);
         end
         default: ok = 1'b0;
      endcase
   end

   assign opcode  = opc;
   assign len     = len_m;
   assign illegal = !ok || (len_m == ILEN_NONE);

endmodule

// File: rtl/instr_encoder.sv
// Sequential 6502 instruction encoder: accepts a mnemonic/mode/index/operand
// request and streams the 1-3 byte machine code out over valid/ready.
// Ports: clk, rst_n; request in_valid/in_ready/in_op/in_adr_mode/in_index/
// in_operand; byte stream out_valid/out_ready/out_byte/out_last; err pulse.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_op,
   input  logic [4:0]  in_adr_mode,
   input  logic        in_index,
   input  logic [15:0] in_operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic        out_last,
   output logic        err
);

   enc_state_e        state_q, state_d;
   enc_req_t          req_q, req_d;
   logic [BYTE_W-1:0] opcode_q, opcode_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              out_valid_q, out_valid_d;
   logic [BYTE_W-1:0] out_byte_q, out_byte_d;
   logic              out_last_q, out_last_d;
   logic              err_q, err_d;

   logic [BYTE_W-1:0] lut_opcode;
   logic [LEN_W-1:0]  lut_len;
   logic              lut_illegal;

   opcode_lut u_lut (
      .op       (req_q.op),
      .adr_mode (req_q.mode),
      .index    (req_q.index),
      .opcode   (lut_opcode),
      .len      (lut_len),
      .illegal  (lut_illegal)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         opcode_q    <= '0;
         len_q       <= ILEN_NONE;
         out_valid_q <= 1'b0;
         out_byte_q  <= '0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         opcode_q    <= opcode_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
         out_byte_q  <= out_byte_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   // Next state and registered-output values
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      opcode_d    = opcode_q;
      len_d       = len_q;
      out_valid_d = out_valid_q;
      out_byte_d  = out_byte_q;
      out_last_d  = out_last_q;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               req_d   = '{op: in_op, mode: in_adr_mode, index: in_index,
                           operand: in_operand};
               state_d = ST_CHK;
            end
         end
         ST_CHK: begin
            opcode_d = lut_opcode;
            len_d    = lut_len;
            if (lut_illegal) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OPC;
            end
         end
         // First OPC cycle loads the opcode; later cycles wait for the sink
         ST_OPC: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_byte_d  = opcode_q;
               out_last_d  = (len_q == ILEN_1);
            end else if (out_ready) begin
               if (len_q == ILEN_1) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  out_byte_d = req_q.operand[7:0];
                  out_last_d = (len_q == ILEN_2);
                  state_d    = ST_LO;
               end
            end
         end
         ST_LO: begin
            if (out_ready) begin
               if (len_q == ILEN_2) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  out_byte_d = req_q.operand[15:8];
                  out_last_d = 1'b1;
                  state_d    = ST_HI;
               end
            end
         end
         ST_HI: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_byte  = out_byte_q;
   assign out_last  = out_last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a scoreboard queue of expected
// bytes filled at request time and drained by a byte monitor.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_op;
   logic [4:0]  in_adr_mode;
   logic        in_index;
   logic [15:0] in_operand;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        err;

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks     = 0;
   int   n_fail       = 0;
   int   err_seen     = 0;
   int   stall_cycles = 0;
   int   wait_cnt     = 0;
   bit   hs_pending   = 1'b0;

   instr_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_adr_mode (in_adr_mode),
      .in_index    (in_index),
      .in_operand  (in_operand),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_byte    (out_byte),
      .out_last    (out_last),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Byte monitor: pops on handshake, checks hold-stable while stalled
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (err) err_seen++;
         if (out_valid) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               if (out_ready) begin
                  e = exp_q.pop_front();
                  check("byte", 32'(out_byte), 32'(e.b));
                  check("last", 32'(out_last), 32'(e.last));
               end else begin
                  check("stall_byte", 32'(out_byte), 32'(exp_q[0].b));
                  check("stall_last", 32'(out_last), 32'(exp_q[0].last));
               end
            end
            if (out_ready) hs_pending = 1'b1;
         end
      end
   end

   // Sink: hold out_ready low for stall_cycles on every new byte
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || hs_pending) wait_cnt = 0;
         hs_pending = 1'b0;
         if (out_valid && wait_cnt < stall_cycles) begin
            out_ready = 1'b0;
            wait_cnt++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Present a request and return just after the accepting edge (+1)
   task automatic accept(input logic [5:0] op, input logic [4:0] mode,
                         input logic idx, input logic [15:0] opr);
      int g = 0;
      in_valid    = 1'b1;
      in_op       = op;
      in_adr_mode = mode;
      in_index    = idx;
      in_operand  = opr;
      while (!in_ready && g < 50) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("accept_wait", 32'(g < 50), 32'd1);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_op       = 6'($urandom);
      in_adr_mode = 5'($urandom);
      in_index    = 1'($urandom);
      in_operand  = 16'($urandom);
   endtask

   // n = expected length, 0 means the request must be rejected
   task automatic send(input string tag, input logic [5:0] op, input logic [4:0] mode,
                       input logic idx, input logic [15:0] opr,
                       input logic [7:0] opc, input int n);
      int lat = 0;
      int err0;
      if (n >= 1) exp_q.push_back('{b: opc, last: (n == 1)});
      if (n >= 2) exp_q.push_back('{b: opr[7:0], last: (n == 2)});
      if (n == 3) exp_q.push_back('{b: opr[15:8], last: 1'b1});
      err0 = err_seen;
      accept(op, mode, idx, opr);
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!in_ready && lat < 200);
      if (stall_cycles == 0)
         check({tag, "_ready_lat"}, 32'(lat), (n == 0) ? 32'd1 : 32'(n + 2));
      else
         check({tag, "_timeout"}, 32'(lat < 200), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_err"}, 32'(err_seen - err0), (n == 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_op       = '0;
      in_adr_mode = '0;
      in_index    = 1'b0;
      in_operand  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_byte", 32'(out_byte), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send("lda_imm",    OP_LDA, ADR_IMM,         ADR_INDEX_X, 16'h0042, 8'hA9, 2);
      send("sta_absx",   OP_STA, ADR_ABS_X_Y,     ADR_INDEX_X, 16'h1234, 8'h9D, 3);
      send("adc_absy",   OP_ADC, ADR_ABS_X_Y,     ADR_INDEX_Y, 16'h1234, 8'h79, 3);
      send("jmp_ind",    OP_JMP, ADR_ABS_IND,     ADR_INDEX_X, 16'hFFFC, 8'h6C, 3);
      send("jsr",        OP_JSR, ADR_ABS_JSR,     ADR_INDEX_X, 16'hC000, 8'h20, 3);
      send("inx",        OP_INX, ADR_IMPL,        ADR_INDEX_X, 16'hBEEF, 8'hE8, 1);
      send("asl_a",      OP_ASL, ADR_ACCUM,       ADR_INDEX_X, 16'h0000, 8'h0A, 1);
      send("inc_zrmw",   OP_INC, ADR_ZPG_RMW,     ADR_INDEX_X, 16'hAB10, 8'hE6, 2);
      send("ror_absx",   OP_ROR, ADR_ABS_X_Y_RMW, ADR_INDEX_X, 16'h0300, 8'h7E, 3);
      send("dec_abs",    OP_DEC, ADR_ABS,         ADR_INDEX_X, 16'h4455, 8'hCE, 3);
      send("ldx_zpy",    OP_LDX, ADR_ZPG_X_Y,     ADR_INDEX_Y, 16'h0080, 8'hB6, 2);
      send("sty_zpx",    OP_STY, ADR_ZPG_X_Y,     ADR_INDEX_X, 16'h0081, 8'h94, 2);
      send("lda_indy",   OP_LDA, ADR_ZPG_IND_Y,   ADR_INDEX_Y, 16'h0010, 8'hB1, 2);
      send("eor_xind",   OP_EOR, ADR_ABS_X_IND,   ADR_INDEX_X, 16'h0020, 8'h41, 2);
      send("cpy_imm",    OP_CPY, ADR_IMM,         ADR_INDEX_X, 16'h0007, 8'hC0, 2);
      send("beq",        OP_BEQ, ADR_REL,         ADR_INDEX_X, 16'h0005, 8'hF0, 2);
      send("pha",        OP_PHA, ADR_STACK_PUSH,  ADR_INDEX_X, 16'h0000, 8'h48, 1);
      send("rts",        OP_RTS, ADR_STACK_RTS,   ADR_INDEX_X, 16'h0000, 8'h60, 1);
      send("sed",        OP_SED, ADR_IMPL,        ADR_INDEX_X, 16'h0000, 8'hF8, 1);

      send("ill_sta_imm", OP_STA, ADR_IMM,        ADR_INDEX_X, 16'h0042, 8'h00, 0);
      send("ill_stx_zpx", OP_STX, ADR_ZPG_X_Y,    ADR_INDEX_X, 16'h0042, 8'h00, 0);
      send("ill_ldy_absy",OP_LDY, ADR_ABS_X_Y,    ADR_INDEX_Y, 16'h1234, 8'h00, 0);
      send("ill_jmp_zpg", OP_JMP, ADR_ZPG,        ADR_INDEX_X, 16'h0042, 8'h00, 0);
      send("ill_inval",   OP_LDA, ADR_INVAL,      ADR_INDEX_X, 16'h0042, 8'h00, 0);
      send("ill_op63",    6'd63,  ADR_IMM,        ADR_INDEX_X, 16'h0042, 8'h00, 0);

      stall_cycles = 3;
      send("bne_stall",  OP_BNE, ADR_REL,         ADR_INDEX_X, 16'h00FE, 8'hD0, 2);

      // Reset while the low operand byte is pending
      exp_q.push_back('{b: 8'hAD, last: 1'b0});
      exp_q.push_back('{b: 8'h78, last: 1'b0});
      exp_q.push_back('{b: 8'h56, last: 1'b1});
      accept(OP_LDA, ADR_ABS, ADR_INDEX_X, 16'h5678);
      g = 0;
      do begin
         @(posedge clk);
         #2;
         g++;
      end while (!(out_valid && out_byte == 8'h78) && g < 100);
      check("rst_reach_lo", 32'(g < 100), 32'd1);
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_byte", 32'(out_byte), 32'd0);
      check("arst_out_last", 32'(out_last), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_err", 32'(err), 32'd0);
      stall_cycles = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("rst_no_leftover", 32'(out_valid), 32'd0);
      send("post_rst",   OP_LDA, ADR_ABS,         ADR_INDEX_X, 16'h5678, 8'hAD, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
